// File: rtl/cla_pkg.sv
// Shared types and defaults for the CLA accumulator slice.
//   acc_state_t   : accumulator FSM states (ACC collects operands, DONE presents result)
//   CLA_DEFAULT_N : default datapath width
package cla_pkg;

    typedef enum logic {ACC, DONE} acc_state_t;

    localparam int CLA_DEFAULT_N = 32;

endpackage

// File: rtl/cla_32bit.sv
// Parallel-prefix carry-lookahead adder: {c_out, S} = A + B + c_in.
// Ports:
//   A, B   : N-bit addends
//   c_in   : carry in
//   S      : N-bit sum
//   c_out  : carry out of the MSB
module cla_32bit #(
    parameter int N = 32
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         c_in,
    output logic [N-1:0] S,
    output logic         c_out
);

    logic [N-1:0] p;
    logic [N-1:0] g;
    logic [N-1:0] pp;

    // Kogge-Stone prefix; c_in is folded into bit 0's generate so g[i] ends
    // up as the carry out of bit i. Each level walks from MSB down so the
    // lower-index operand still holds the previous level's value.
    always_comb begin
        p    = A ^ B;
        g    = A & B;
        g[0] = g[0] | (p[0] & c_in);
        pp   = p;
        for (int unsigned d = 1; d < N; d = d * 2) begin
            for (int unsigned k = 0; k < N - d; k++) begin
                g[N-1-k]  = g[N-1-k] | (pp[N-1-k] & g[N-1-k-d]);
                pp[N-1-k] = pp[N-1-k] & pp[N-1-k-d];
            end
        end
        S     = p ^ {g[N-2:0], c_in};
        c_out = g[N-1];
    end

endmodule

// File: rtl/cla_accumulator.sv
// Stream accumulator around cla_32bit: sums a burst of operands and presents
// the total with sticky unsigned-carry and signed-overflow flags.
// Ports:
//   clk, rst_n                       : clock, async active-low reset
//   in_valid/in_ready/in_data/in_last: operand stream (one per cycle)
//   out_valid/out_ready              : result handshake
//   out_sum, out_carry, out_ovf      : sum mod 2^N, sticky carry, sticky overflow
//   out_count                        : operands summed in the burst
module cla_accumulator
    import cla_pkg::*;
#(
    parameter int N       = CLA_DEFAULT_N,
    parameter int MAX_CNT = 16,
    parameter int CNT_W   = $clog2(MAX_CNT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_sum,
    output logic             out_carry,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_count
);

    acc_state_t       state_q;
    logic [N-1:0]     acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic             ovf_q;

    logic [N-1:0]     acc_d;
    logic             cout_d;
    logic             ovf_add;
    logic             in_hs;
    logic             burst_end;

    // The accumulator register feeds the adder directly; nothing else sits
    // on that path.
    cla_32bit #(
        .N(N)
    ) u_add (
        .A    (acc_q),
        .B    (in_data),
        .c_in (1'b0),
        .S    (acc_d),
        .c_out(cout_d)
    );

    // Signed overflow: operands share a sign and the result's sign differs.
    assign ovf_add   = (acc_q[N-1] == in_data[N-1]) & (acc_d[N-1] != acc_q[N-1]);
    assign in_hs     = in_valid & (state_q == ACC);
    assign burst_end = in_last | (cnt_q == CNT_W'(MAX_CNT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                ACC: begin
                    if (in_hs) begin
                        acc_q   <= acc_d;
                        carry_q <= carry_q | cout_d;
                        ovf_q   <= ovf_q | ovf_add;
                        cnt_q   <= cnt_q + CNT_W'(1);
                        if (burst_end) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        carry_q <= 1'b0;
                        ovf_q   <= 1'b0;
                        state_q <= ACC;
                    end
                end
                default: state_q <= ACC;
            endcase
        end
    end

    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == DONE);
    assign out_sum   = acc_q;
    assign out_carry = carry_q;
    assign out_ovf   = ovf_q;
    assign out_count = cnt_q;

endmodule

// File: tb/tb_cla_accumulator.sv
module tb_cla_accumulator;

    localparam int N       = 32;
    localparam int MAX_CNT = 16;
    localparam int CNT_W   = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_sum;
    logic             out_carry;
    logic             out_ovf;
    logic [CNT_W-1:0] out_count;

    cla_accumulator #(
        .N      (N),
        .MAX_CNT(MAX_CNT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_carry(out_carry),
        .out_ovf  (out_ovf),
        .out_count(out_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] sum;
        logic        c;
        logic        o;
        int          cnt;
    } res_t;

    res_t sb[$];
    res_t mon_e;

    int total = 0;
    int bad   = 0;

    // Reference model: plain wide arithmetic over the burst.
    logic [31:0] m_acc;
    logic        m_c;
    logic        m_o;
    int          m_cnt;
    bit          m_done;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_acc = '0;
        m_c   = 1'b0;
        m_o   = 1'b0;
        m_cnt = 0;
    endtask

    task automatic model_add(input logic [31:0] d);
        logic [32:0] w;
        longint      s;
        w = {1'b0, m_acc} + {1'b0, d};
        s = longint'($signed(m_acc)) + longint'($signed(d));
        m_c   = m_c | w[32];
        m_o   = m_o | (s > 64'sd2147483647 || s < -64'sd2147483648);
        m_acc = w[31:0];
        m_cnt++;
    endtask

    // One clock of stimulus; checks handshake-side outputs against the model.
    task automatic cycle(input logic v, input logic [31:0] d, input logic l,
                         input logic r, output bit accepted);
        res_t e;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
        #1;
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_done});
        chk("in_ready", {31'd0, in_ready}, {31'd0, !m_done});
        accepted = 1'b0;
        if (!m_done) begin
            if (v) begin
                accepted = 1'b1;
                model_add(d);
                if (l || m_cnt == MAX_CNT) begin
                    e.sum = m_acc;
                    e.c   = m_c;
                    e.o   = m_o;
                    e.cnt = m_cnt;
                    sb.push_back(e);
                    model_clear();
                    m_done = 1'b1;
                end
            end
        end else if (r) begin
            m_done = 1'b0;
        end
    endtask

    task automatic send(input logic [31:0] d, input logic l, input logic r);
        bit a;
        int n;
        a = 1'b0;
        n = 0;
        while (!a && n < 50) begin
            cycle(1'b1, d, l, r, a);
            n++;
        end
        if (!a) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic result(input logic [31:0] s, input logic c, input logic o, input int cnt);
        chk("dir_valid", {31'd0, out_valid}, 32'd1);
        chk("dir_sum", out_sum, s);
        chk("dir_carry", {31'd0, out_carry}, {31'd0, c});
        chk("dir_ovf", {31'd0, out_ovf}, {31'd0, o});
        chk("dir_count", {27'd0, out_count}, cnt);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #3;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum", out_sum, 32'd0);
        chk("rst_carry", {31'd0, out_carry}, 32'd0);
        chk("rst_ovf", {31'd0, out_ovf}, 32'd0);
        chk("rst_count", {27'd0, out_count}, 32'd0);
        sb.delete();
        model_clear();
        m_done = 1'b0;
        @(negedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    // Monitor: compares every presented result against the scoreboard head,
    // so a result held under backpressure is checked on every cycle.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_n === 1'b1 && out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("sb_empty", 32'd0, 32'd1);
                end else begin
                    mon_e = sb[0];
                    chk("sb_sum", out_sum, mon_e.sum);
                    chk("sb_carry", {31'd0, out_carry}, {31'd0, mon_e.c});
                    chk("sb_ovf", {31'd0, out_ovf}, {31'd0, mon_e.o});
                    chk("sb_count", {27'd0, out_count}, mon_e.cnt);
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          a;
        logic [31:0] d;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        model_clear();
        m_done = 1'b0;
        #1;
        chk("por_valid", {31'd0, out_valid}, 32'd0);
        chk("por_sum", out_sum, 32'd0);
        rst_n = 1'b1;
        do_reset();

        send(32'd5, 1'b0, 1'b1);
        send(32'd10, 1'b0, 1'b1);
        send(32'd15, 1'b1, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1, a);
        result(32'd30, 1'b0, 1'b0, 3);

        send(32'hFFFF_FFFF, 1'b0, 1'b1);
        send(32'h0000_0002, 1'b1, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1, a);
        result(32'h0000_0001, 1'b1, 1'b0, 2);

        send(32'h7FFF_FFFF, 1'b0, 1'b1);
        send(32'h0000_0001, 1'b1, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1, a);
        result(32'h8000_0000, 1'b0, 1'b1, 2);
        send(32'd1, 1'b1, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1, a);
        result(32'd1, 1'b0, 1'b0, 1);

        // 20 operands of 1, no in_last: auto-terminate at 16.
        for (int i = 0; i < 16; i++) send(32'd1, 1'b0, 1'b1);
        cycle(1'b1, 32'd1, 1'b0, 1'b1, a);
        chk("op17_blocked", {31'd0, a}, 32'd0);
        result(32'd16, 1'b0, 1'b0, 16);
        for (int i = 0; i < 4; i++) send(32'd1, 1'b0, 1'b1);
        send(32'd0, 1'b1, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1, a);
        result(32'd4, 1'b0, 1'b0, 5);

        // Backpressure, then reset discards the pending result.
        send(32'd9, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, $urandom, 1'($urandom % 2), 1'b0, a);
        result(32'd9, 1'b0, 1'b0, 1);
        do_reset();

        for (int i = 0; i < 400; i++) begin
            case ($urandom % 5)
                0: d = 32'h7FFF_FFFF;
                1: d = 32'h8000_0000;
                2: d = 32'hFFFF_FFFF;
                default: d = $urandom;
            endcase
            cycle(1'($urandom % 4 != 0), d, 1'($urandom % 6 == 0),
                  1'($urandom % 10 < 7), a);
            if (i == 200) do_reset();
        end

        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b0, 1'b1, a);
        chk("sb_drained", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cla_accumulator.md
Name: cla_accumulator

Overview:
- Stream accumulator that sits directly upstream of result consumers and wraps the team's cla_32bit adder as its datapath.
- Accepts a burst of N-bit operands over a valid/ready handshake and sums them into a running accumulator, one operand per cycle.
- When a burst ends, presents the sum on a valid/ready output together with a sticky unsigned carry, a sticky signed overflow and the operand count.

Parameters:
- N, 32, operand/accumulator width; passed through to cla_32bit.
- MAX_CNT, 16, maximum number of operands per burst; the burst auto-terminates on the MAX_CNT-th operand.
- CNT_W, $clog2(MAX_CNT+1), width of the operand counter (must hold MAX_CNT).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand present.
- in_ready  output  1  block can accept an operand.
- in_data  input  N  operand, two's complement or unsigned (same bits).
- in_last  input  1  final operand of the burst; qualified by the handshake.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_sum  output  N  accumulated sum modulo 2^N.
- out_carry  output  1  sticky: any adder c_out was 1 during the burst (unsigned wrap).
- out_ovf  output  1  sticky: any add produced signed overflow.
- out_count  output  CNT_W  number of operands summed in the burst.

Behaviour:
- Reset (async, rst_n=0):
  - state=ACC; accumulator, count, carry and ovf all cleared.
  - out_valid=0, out_sum=0, out_carry=0, out_ovf=0, out_count=0.
  - in_ready=1 from the first clock edge after release.
- FSM with two states, ACC and DONE:
  - ACC: in_ready=1, out_valid=0.
    - Handshake = in_valid & in_ready.
    - On handshake, at the clock edge: acc <= S from cla_32bit(A=acc, B=in_data, c_in=0).
    - carry_stk |= c_out.
    - ovf_stk |= (acc[N-1]==in_data[N-1]) & (S[N-1]!=acc[N-1]).
    - count <= count+1.
    - If in_last=1 or count==MAX_CNT-1, go to DONE.
  - DONE: in_ready=0, out_valid=1.
    - out_* are driven directly from the registers and held stable while out_ready=0.
    - in_valid, in_data and in_last are ignored.
    - On out_valid & out_ready: clear acc, count and sticky flags, then go to ACC.
- Timing:
  - Latency: out_valid asserts on the cycle after the last-operand handshake.
  - Throughput: one operand per cycle in ACC, plus one mandatory bubble cycle for each result in DONE.
  - A burst of K operands with out_ready=1 occupies K+1 cycles.
- Outputs in ACC:
  - out_sum, out_carry, out_ovf and out_count show the running registers.
  - Consumers use them only when out_valid=1.
- Arithmetic rules:
  - Sum wraps modulo 2^N.
  - The sticky flags never clear within a burst, so a later add cannot cancel an earlier carry or overflow.
- Boundary cases:
  - in_last on the first operand gives count=1 and sum=operand.
  - in_last coinciding with count==MAX_CNT-1 is a single termination, not a double.
  - No zero-length bursts: a result exists only after at least one operand.
  - Reset mid-burst or while in DONE discards everything; out_valid drops asynchronously.
- The combinational path is the cla_32bit carry chain only; no other logic sits between the acc register and the adder inputs.

Decomposition:
- Shared package cla_pkg holds:
  - typedef enum logic {ACC, DONE} acc_state_t;
  - localparam default N=32.
- Sub-module: one instance of the existing cla_32bit (ports A, B, c_in, S, c_out).
- All other logic stays in cla_accumulator.

Test Plan:
- Reset: assert rst_n=0 mid-cycle → out_valid=0, outputs 0 immediately; after release in_ready=1 at the first clk edge.
- Burst 5, 10, 15 (in_last on 15), out_ready=1 → out_valid on the cycle after 15; out_sum=30, out_count=3, out_carry=0, out_ovf=0; in_ready=0 for one cycle.
- Burst 0xFFFFFFFF, 0x00000002 (last) → out_sum=0x00000001, out_carry=1, out_ovf=0, out_count=2.
- Burst 0x7FFFFFFF, 0x00000001 (last) → out_sum=0x80000000, out_ovf=1, out_carry=0; then a second burst 1 (last) → out_ovf=0 (flags cleared between bursts).
- 20 back-to-back operands of value 1, no in_last → auto-terminate at the 16th: out_sum=16, out_count=16; the 17th operand is accepted only after the result handshake and begins a new burst.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 → in_ready=0 and out_* stable throughout; then pull rst_n low for 1 cycle → out_valid=0 and the pending result is lost.
